capture_sequencer: RTL and testbench



---
 rtl/capture_seq_pkg.sv | 16 +
 rtl/capture_watchdog.sv | 39 +++
 rtl/capture_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_seq_pkg.sv
// Shared state encoding and default timing constants for the capture sequencer.
package capture_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAM_RST,
        ARM,
        CAPTURE,
        DRAIN,
        ERROR
    } state_t;

    localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd1_000_000;
    localparam int unsigned DEF_RST_CYCLES     = 4;

endpackage

// File: rtl/capture_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear, saturating at TIMEOUT_CYCLES.
module capture_watchdog
    import capture_seq_pkg::*;
#(
    parameter int unsigned     TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(DEF_TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (enable && (cnt != TIMEOUT_CYCLES)) begin
            cnt_nxt = cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Flags the cycle whose edge lands the count on the limit, so the error
    // appears exactly TIMEOUT_CYCLES idle cycles after the last clear.
    assign expired = enable && !clear && (cnt_nxt == TIMEOUT_CYCLES);

endmodule

// File: rtl/capture_sequencer.sv
// Camera capture sequencer: front-end reset, shutter, word counting and drain handshake per shot.
// Optional build macro CAPTURE_STATS_EN adds the last_shot_cycles output.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for start, capture block held in reset
//   CAM_RST | capture block reset for RST_CYCLES cycles
//   ARM     | single-cycle shutter pulse
//   CAPTURE | counting FIFO writes, watchdog running
//   DRAIN   | waiting for the host to empty the FIFO
//   ERROR   | timeout or overflow, flags held until next start
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int unsigned     WORD_W         = 16,
    parameter int unsigned     SHOT_W         = 8,
    parameter int unsigned     TO_W           = 24,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(DEF_TIMEOUT_CYCLES),
    parameter int unsigned     RST_CYCLES     = DEF_RST_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_words,
    input  logic [SHOT_W-1:0] cfg_shots,
    input  logic              cam_fifo_wr,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              cam_reset,
    output logic              shutter,
    output logic              drain_req,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_overflow,
    output logic [SHOT_W-1:0] shot_idx,
    output logic [WORD_W-1:0] word_count
`ifdef CAPTURE_STATS_EN
    ,
    output logic [TO_W-1:0]   last_shot_cycles
`endif
);

    localparam int unsigned RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] cfg_words_q;
    logic [SHOT_W-1:0] cfg_shots_q;
    logic [RC_W-1:0]   rst_cnt;
    logic              done_nxt;
    logic              accept;
    logic              shot_inc;
    logic              word_inc;
    logic              set_to;
    logic              set_ov;
    logic              wd_expired;

    capture_watchdog #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state != CAPTURE) || cam_fifo_wr),
        .enable  (state == CAPTURE),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        shot_inc  = 1'b0;
        word_inc  = 1'b0;
        set_to    = 1'b0;
        set_ov    = 1'b0;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, ERROR: begin
                    if (start && !abort && (cfg_words != '0) && (cfg_shots != '0)) begin
                        accept    = 1'b1;
                        state_nxt = CAM_RST;
                    end
                end
                CAM_RST: begin
                    if (rst_cnt == '0) state_nxt = ARM;
                end
                ARM: begin
                    state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    // Overflow outranks both the final word and the watchdog.
                    if (cam_fifo_wr && fifo_full) begin
                        set_ov    = 1'b1;
                        state_nxt = ERROR;
                    end else if (cam_fifo_wr) begin
                        word_inc = (word_count != cfg_words_q);
                        if (word_count == cfg_words_q - 1'b1) state_nxt = DRAIN;
                    end else if (wd_expired) begin
                        set_to    = 1'b1;
                        state_nxt = ERROR;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        if (shot_idx == cfg_shots_q - 1'b1) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            shot_inc  = 1'b1;
                            state_nxt = CAM_RST;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cam_reset = 1'b0;
        shutter   = 1'b0;
        drain_req = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE, ERROR: cam_reset = 1'b1;
            CAM_RST: begin
                cam_reset = 1'b1;
                busy      = 1'b1;
            end
            ARM: begin
                shutter = 1'b1;
                busy    = 1'b1;
            end
            CAPTURE: busy = 1'b1;
            DRAIN: begin
                drain_req = 1'b1;
                busy      = 1'b1;
            end
            default: cam_reset = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cfg_words_q  <= '0;
            cfg_shots_q  <= '0;
            rst_cnt      <= RC_LOAD;
            shot_idx     <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if ((state == CAM_RST) && (rst_cnt != '0)) begin
                rst_cnt <= rst_cnt - 1'b1;
            end else if (state != CAM_RST) begin
                rst_cnt <= RC_LOAD;
            end
            if (accept) begin
                cfg_words_q  <= cfg_words;
                cfg_shots_q  <= cfg_shots;
                shot_idx     <= '0;
                err_timeout  <= 1'b0;
                err_overflow <= 1'b0;
            end else begin
                if (shot_inc) shot_idx <= shot_idx + 1'b1;
                if (set_to) err_timeout <= 1'b1;
                if (set_ov) err_overflow <= 1'b1;
            end
            if ((state_nxt == CAM_RST) && (state != CAM_RST)) begin
                word_count <= '0;
            end else if (word_inc) begin
                word_count <= word_count + 1'b1;
            end
        end
    end

`ifdef CAPTURE_STATS_EN
    logic [TO_W-1:0] cap_cycles;
    logic [TO_W-1:0] cap_cycles_inc;

    assign cap_cycles_inc = (&cap_cycles) ? cap_cycles : cap_cycles + TO_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_cycles       <= '0;
            last_shot_cycles <= '0;
        end else begin
            cap_cycles <= (state == CAPTURE) ? cap_cycles_inc : '0;
            // Includes the cycle carrying the final word.
            if ((state == CAPTURE) && (state_nxt == DRAIN)) last_shot_cycles <= cap_cycles_inc;
        end
    end
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench: expected output segments (vector + hold length) are queued, a monitor compares each completed segment.
module tb_capture_sequencer;

    localparam int WORD_W = 16;
    localparam int SHOT_W = 8;
    localparam int TO_W   = 24;

    typedef struct {
        logic [30:0] vec;
        int unsigned len;
    } exp_t;

    logic              clk         = 1'b0;
    logic              rst         = 1'b1;
    logic              start       = 1'b0;
    logic              abort       = 1'b0;
    logic [WORD_W-1:0] cfg_words   = '0;
    logic [SHOT_W-1:0] cfg_shots   = '0;
    logic              cam_fifo_wr = 1'b0;
    logic              fifo_full   = 1'b0;
    logic              fifo_empty  = 1'b0;
    logic              cam_reset, shutter, drain_req, busy, done, err_timeout, err_overflow;
    logic [SHOT_W-1:0] shot_idx;
    logic [WORD_W-1:0] word_count;
`ifdef CAPTURE_STATS_EN
    logic [TO_W-1:0]   last_shot_cycles;
`endif
    logic [30:0]       outv;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    capture_sequencer #(
        .WORD_W         (WORD_W),
        .SHOT_W         (SHOT_W),
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (24'd100),
        .RST_CYCLES     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_words    (cfg_words),
        .cfg_shots    (cfg_shots),
        .cam_fifo_wr  (cam_fifo_wr),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .cam_reset    (cam_reset),
        .shutter      (shutter),
        .drain_req    (drain_req),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow),
        .shot_idx     (shot_idx),
        .word_count   (word_count)
`ifdef CAPTURE_STATS_EN
        ,
        .last_shot_cycles (last_shot_cycles)
`endif
    );

    assign outv = {cam_reset, shutter, drain_req, busy, done, err_timeout, err_overflow, shot_idx, word_count};

    function automatic logic [30:0] mk(input logic cr, input logic sh, input logic dr, input logic bz,
                                       input logic dn, input logic to, input logic ov,
                                       input logic [7:0] s, input logic [15:0] w);
        return {cr, sh, dr, bz, dn, to, ov, s, w};
    endfunction

    task automatic ex(input logic [30:0] v, input int unsigned n);
        exp_t e;
        e.vec = v;
        e.len = n;
        exp_q.push_back(e);
    endtask

    // Front-end reset (4 cycles) followed by the single shutter cycle.
    task automatic ex_shot(input logic [7:0] s);
        ex(mk(1, 0, 0, 1, 0, 0, 0, s, 16'd0), 4);
        ex(mk(0, 1, 0, 1, 0, 0, 0, s, 16'd0), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] w, input logic [7:0] s);
        cfg_words = w;
        cfg_shots = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_shutter();
        for (int i = 0; i < 50; i++) begin
            if (shutter) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_shutter: shutter=%0b after 50 cycles, required 1", shutter);
    endtask

    task automatic wait_err();
        for (int i = 0; i < 150; i++) begin
            if (err_timeout || err_overflow) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_err: no error flag after 150 cycles, required one");
    endtask

    task automatic words(input int n);
        cam_fifo_wr = 1'b1;
        repeat (n) tick();
        cam_fifo_wr = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        fifo_empty = 1'b1;
        tick();
        fifo_empty = 1'b0;
    endtask

    // Monitor: each time the output vector changes, the finished segment is checked.
    initial begin
        logic [30:0] prev;
        logic [30:0] cur;
        int unsigned run;
        exp_t        e;
        @(posedge clk);
        @(negedge clk);
        prev = outv;
        run  = 1;
        forever begin
            @(negedge clk);
            cur = outv;
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seg_unexpected: got vec=%h len=%0d, required none", prev, run);
                end else begin
                    e = exp_q.pop_front();
                    if ((prev !== e.vec) || ((e.len != 0) && (run != e.len))) begin
                        errors++;
                        $display("FAIL seg_%0d: got vec=%h len=%0d, required vec=%h len=%0d",
                                 checks, prev, run, e.vec, e.len);
                    end
                end
                prev = cur;
                run  = 1;
            end else begin
                run++;
            end
        end
    end

    initial begin
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd0, 16'd0), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) tick();

        // Basic shot: 4 words, one shot.
        ex_shot(8'd0);
        for (int w = 0; w < 4; w++) ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'(w)), 1);
        ex(mk(0, 0, 1, 1, 0, 0, 0, 8'd0, 16'd4), 3);
        ex(mk(1, 0, 0, 0, 1, 0, 0, 8'd0, 16'd4), 1);
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd0, 16'd4), 0);
        go(16'd4, 8'd1);
        wait_shutter();
        tick();
        words(4);
        drain(2);
        repeat (3) tick();
`ifdef CAPTURE_STATS_EN
        checks++;
        if (last_shot_cycles !== 24'd4) begin
            errors++;
            $display("FAIL last_shot_cycles: got %0d, required 4", last_shot_cycles);
        end
`endif

        // Multi-shot: three shots of two words each, one done at the end.
        for (int s = 0; s < 3; s++) begin
            ex_shot(8'(s));
            ex(mk(0, 0, 0, 1, 0, 0, 0, 8'(s), 16'd0), 1);
            ex(mk(0, 0, 0, 1, 0, 0, 0, 8'(s), 16'd1), 1);
            ex(mk(0, 0, 1, 1, 0, 0, 0, 8'(s), 16'd2), 2);
        end
        ex(mk(1, 0, 0, 0, 1, 0, 0, 8'd2, 16'd2), 1);
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd2, 16'd2), 0);
        go(16'd2, 8'd3);
        for (int s = 0; s < 3; s++) begin
            wait_shutter();
            tick();
            words(2);
            drain(1);
        end
        repeat (3) tick();

        // Timeout: 100 idle cycles in CAPTURE, then a fresh start clears the flag.
        ex_shot(8'd0);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd0), 100);
        ex(mk(1, 0, 0, 0, 0, 1, 0, 8'd0, 16'd0), 0);
        go(16'd3, 8'd1);
        wait_shutter();
        tick();
        wait_err();
        repeat (3) tick();
        ex_shot(8'd0);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd0), 1);
        ex(mk(0, 0, 1, 1, 0, 0, 0, 8'd0, 16'd1), 1);
        ex(mk(1, 0, 0, 0, 1, 0, 0, 8'd0, 16'd1), 1);
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd0, 16'd1), 0);
        go(16'd1, 8'd1);
        wait_shutter();
        tick();
        words(1);
        drain(0);
        repeat (3) tick();

        // Overflow on the final word, then abort out of ERROR (flags hold).
        ex_shot(8'd0);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd0), 1);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd1), 1);
        ex(mk(1, 0, 0, 0, 0, 0, 1, 8'd0, 16'd1), 0);
        go(16'd2, 8'd1);
        wait_shutter();
        tick();
        cam_fifo_wr = 1'b1;
        tick();
        fifo_full = 1'b1;
        tick();
        cam_fifo_wr = 1'b0;
        fifo_full   = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();

        // Abort during CAPTURE: busy drops on the next edge, no done.
        ex_shot(8'd0);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd0), 1);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd1), 2);
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd0, 16'd1), 0);
        go(16'd4, 8'd2);
        wait_shutter();
        tick();
        words(1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();

        // Ignored starts: zero word count, and start together with abort in IDLE.
        go(16'd0, 8'd1);
        tick();
        abort = 1'b1;
        go(16'd3, 8'd1);
        abort = 1'b0;
        repeat (3) tick();

        // Start while busy is ignored; rst mid-DRAIN of shot 1; then recovery shot.
        ex_shot(8'd0);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd0), 1);
        ex(mk(0, 0, 1, 1, 0, 0, 0, 8'd0, 16'd1), 1);
        ex_shot(8'd1);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd1, 16'd0), 1);
        ex(mk(0, 0, 1, 1, 0, 0, 0, 8'd1, 16'd1), 2);
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd0, 16'd0), 0);
        ex_shot(8'd0);
        ex(mk(0, 0, 0, 1, 0, 0, 0, 8'd0, 16'd0), 1);
        ex(mk(0, 0, 1, 1, 0, 0, 0, 8'd0, 16'd1), 1);
        ex(mk(1, 0, 0, 0, 1, 0, 0, 8'd0, 16'd1), 1);
        ex(mk(1, 0, 0, 0, 0, 0, 0, 8'd0, 16'd1), 0);
        go(16'd1, 8'd2);
        go(16'd5, 8'd3);
        wait_shutter();
        tick();
        words(1);
        drain(0);
        wait_shutter();
        tick();
        words(1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        go(16'd1, 8'd1);
        wait_shutter();
        tick();
        words(1);
        drain(0);
        repeat (3) tick();

        // Only the final open IDLE segment may remain queued.
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL queue_left: got %0d pending, required 1", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
